// File: rtl/l2_input_arbiter.sv
// rtl/l2_input_arbiter.sv - L2 decode-slot arbiter for flush, response, forward and CPU requests
module l2_input_arbiter #(
    parameter int N_CPU      = 2,
    parameter int L2_SETS    = 256,
    parameter int L2_WAYS    = 8,
    parameter int N_REQS     = 4,
    parameter int STARVE_MAX = 15,
    localparam int CNT_W = $clog2(N_REQS + 1),
    localparam int IDX_W = (N_CPU > 1) ? $clog2(N_CPU) : 1,
    localparam int SET_W = (L2_SETS > 1) ? $clog2(L2_SETS) : 1,
    localparam int WAY_W = (L2_WAYS > 1) ? $clog2(L2_WAYS) : 1,
    localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             decode_en,
    input  logic             flush_valid,
    output logic             flush_ready,
    input  logic             rsp_valid,
    output logic             rsp_ready,
    input  logic             fwd_valid,
    output logic             fwd_ready,
    input  logic             fwd_stall,
    input  logic             fwd_stall_ended,
    input  logic [N_CPU-1:0] cpu_valid,
    output logic [N_CPU-1:0] cpu_ready,
    input  logic             set_conflict,
    input  logic             evict_stall,
    input  logic             ongoing_atomic,
    input  logic [CNT_W-1:0] reqs_cnt,
    output logic             do_flush,
    output logic             do_rsp,
    output logic             do_fwd,
    output logic             do_ongoing_flush,
    output logic             do_cpu_req,
    output logic [IDX_W-1:0] cpu_grant_idx,
    output logic [SET_W-1:0] flush_set,
    output logic [WAY_W-1:0] flush_way,
    output logic             ongoing_flush,
    output logic             flush_done,
    output logic             set_fwd_in_from_stalled,
    output logic             set_cpu_req_from_conflict,
    output logic             idle
);

    typedef enum logic [2:0] {
        WIN_NONE,
        WIN_FLUSH,
        WIN_CPU,
        WIN_RSP,
        WIN_FWD,
        WIN_WALK
    } win_t;

    win_t             win;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] rr_idx;
    logic             rr_hit;
    logic [STV_W-1:0] starve_cnt;
    logic             walk_end;
    logic             walk_step;
    logic             cpu_elig;
    logic             flush_acc;
    logic             fwd_win;
    logic             starved;
    logic             walk_last;
    int               cand;

    assign cpu_elig  = ((|cpu_valid) || set_conflict) && !evict_stall &&
                       ((reqs_cnt != '0) || ongoing_atomic) && !ongoing_flush;
    assign flush_acc = flush_valid && (reqs_cnt == CNT_W'(N_REQS)) && !ongoing_flush;
    assign fwd_win   = (fwd_valid && !fwd_stall) || fwd_stall_ended;
    assign starved   = (starve_cnt == STV_W'(STARVE_MAX));
    assign walk_last = (flush_set == SET_W'(L2_SETS - 1)) && (flush_way == WAY_W'(L2_WAYS - 1));

    // Round-robin search plus fixed-priority decision for this decode slot
    always_comb begin
        flush_ready               = 1'b0;
        rsp_ready                 = 1'b0;
        fwd_ready                 = 1'b0;
        cpu_ready                 = '0;
        flush_done                = 1'b0;
        set_fwd_in_from_stalled   = 1'b0;
        set_cpu_req_from_conflict = 1'b0;
        idle                      = 1'b0;
        win                       = WIN_NONE;
        walk_step                 = 1'b0;
        rr_hit                    = 1'b0;
        rr_idx                    = '0;
        cand                      = 0;

        for (int i = 0; i < N_CPU; i++) begin
            cand = (int'(rr_ptr) + i) % N_CPU;
            if (!rr_hit && cpu_valid[cand]) begin
                rr_hit = 1'b1;
                rr_idx = IDX_W'(cand);
            end
        end

        if (decode_en) begin
            if (flush_acc) begin
                win         = WIN_FLUSH;
                flush_ready = 1'b1;
            end else if (cpu_elig && starved) begin
                win = WIN_CPU;
            end else if (rsp_valid) begin
                win       = WIN_RSP;
                rsp_ready = 1'b1;
            end else if (fwd_win) begin
                win = WIN_FWD;
                if (!fwd_stall) begin
                    fwd_ready = 1'b1;
                end else begin
                    set_fwd_in_from_stalled = 1'b1;
                end
            end else if (ongoing_flush) begin
                // The slot belongs to the walk even when it cannot dispatch
                win = WIN_WALK;
                if (walk_end) begin
                    flush_done = 1'b1;
                end else if (!fwd_valid && (reqs_cnt != '0)) begin
                    walk_step = 1'b1;
                end
            end else if (cpu_elig) begin
                win = WIN_CPU;
            end else begin
                idle = 1'b1;
            end

            if (win == WIN_CPU) begin
                if (set_conflict) begin
                    set_cpu_req_from_conflict = 1'b1;
                end else if (rr_hit) begin
                    cpu_ready = N_CPU'(1) << rr_idx;
                end
            end
        end
    end

    // Dispatch strobes capture the slot decision and hold while decode is idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            do_flush         <= 1'b0;
            do_rsp           <= 1'b0;
            do_fwd           <= 1'b0;
            do_ongoing_flush <= 1'b0;
            do_cpu_req       <= 1'b0;
        end else if (decode_en) begin
            do_flush         <= (win == WIN_FLUSH);
            do_rsp           <= (win == WIN_RSP);
            do_fwd           <= (win == WIN_FWD);
            do_ongoing_flush <= walk_step;
            do_cpu_req       <= (win == WIN_CPU);
        end
    end

    // Grant index and round-robin pointer move only on a real port grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_grant_idx <= '0;
            rr_ptr        <= '0;
        end else if (decode_en && (win == WIN_CPU) && !set_conflict && rr_hit) begin
            cpu_grant_idx <= rr_idx;
            rr_ptr        <= (rr_idx == IDX_W'(N_CPU - 1)) ? '0 : rr_idx + 1'b1;
        end
    end

    // Count consecutive slots an eligible CPU loses to rsp/fwd
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (decode_en) begin
            if ((win == WIN_CPU) || !cpu_elig) begin
                starve_cnt <= '0;
            end else if (((win == WIN_RSP) || (win == WIN_FWD)) && !starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // Flush walk: start on accept, step set/way per dispatch, finish one slot after the last line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ongoing_flush <= 1'b0;
            walk_end      <= 1'b0;
            flush_set     <= '0;
            flush_way     <= '0;
        end else if (decode_en) begin
            if (win == WIN_FLUSH) begin
                ongoing_flush <= 1'b1;
                walk_end      <= 1'b0;
                flush_set     <= '0;
                flush_way     <= '0;
            end else if (flush_done) begin
                ongoing_flush <= 1'b0;
                walk_end      <= 1'b0;
                flush_set     <= '0;
                flush_way     <= '0;
            end else if (walk_step) begin
                if (walk_last) begin
                    walk_end <= 1'b1;
                end else if (flush_way == WAY_W'(L2_WAYS - 1)) begin
                    flush_way <= '0;
                    flush_set <= flush_set + 1'b1;
                end else begin
                    flush_way <= flush_way + 1'b1;
                end
            end
        end
    end

endmodule
